// File: rtl/sr_config_loader.sv
// -----------------------------------------------------------------------------
// sr_config_loader
//
// Upstream feeder of the TMIIa shift-register write/read path. On a load
// request it pops NWORDS configuration words from a first-word-fall-through
// config FIFO. It assembles them into a WIDTH-bit shadow image and copies the
// image to din in a single cycle once the last word has arrived. It then raises
// start for two divided-clock periods and keeps busy high until the shift and
// readback window has elapsed.
//
// Ports
//   clk_in          in   1           clock (same clock that feeds the divider)
//   rst             in   1           asynchronous, active-high reset
//   load            in   1           one-cycle request to build and send an image
//   div             in   DIV_WIDTH   division factor, divided clk = clk_in/2**div
//   cfg_fifo_q      in   WORD_WIDTH  FWFT head word, valid while !cfg_fifo_empty
//   cfg_fifo_empty  in   1           config FIFO empty
//   cfg_fifo_rdreq  out  1           pop strobe (combinational)
//   din             out  WIDTH       assembled image, changes only atomically
//   start           out  1           start pulse, stretched to 2 divided periods
//   busy            out  1           high from load acceptance to end of window
//   overrun         out  1           sticky: load seen while not idle
//
// Constraints on the parameters:
//   NWORDS == ceil(WIDTH/WORD_WIDTH), 2**NUM_WIDTH > NWORDS,
//   MAX_DIV < 2**DIV_WIDTH, and COUNT_WIDTH must hold (WIDTH+GUARD)<<MAX_DIV.
// -----------------------------------------------------------------------------
module sr_config_loader #(
  parameter int WIDTH       = 170,
  parameter int WORD_WIDTH  = 32,
  parameter int NWORDS      = 6,
  parameter int NUM_WIDTH   = 4,
  parameter int DIV_WIDTH   = 6,
  parameter int MAX_DIV     = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int GUARD       = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [WORD_WIDTH-1:0] cfg_fifo_q,
  input  logic                  cfg_fifo_empty,
  output logic                  cfg_fifo_rdreq,
  output logic [WIDTH-1:0]      din,
  output logic                  start,
  output logic                  busy,
  output logic                  overrun
);

  // Number of meaningful bits in the final word; the rest of that word is
  // dropped because it lies beyond the top of the image.
  localparam int LAST_BITS = WIDTH - (NWORDS - 1) * WORD_WIDTH;

  localparam logic [DIV_WIDTH-1:0]   MAX_DIV_L  = DIV_WIDTH'(MAX_DIV);
  localparam logic [NUM_WIDTH-1:0]   NWORDS_L   = NUM_WIDTH'(NWORDS);
  localparam logic [NUM_WIDTH-1:0]   LAST_WORD  = NUM_WIDTH'(NWORDS - 1);
  localparam logic [NUM_WIDTH-1:0]   ONE_W      = NUM_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] START_BASE = COUNT_WIDTH'(2);
  localparam logic [COUNT_WIDTH-1:0] WAIT_BASE  = COUNT_WIDTH'(WIDTH + GUARD);
  localparam logic [COUNT_WIDTH-1:0] ONE_C      = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t                 r_state,   w_state_next;
  logic [NUM_WIDTH-1:0]   r_wcnt,    w_wcnt_next;
  logic [COUNT_WIDTH-1:0] r_tcnt,    w_tcnt_next;
  logic [DIV_WIDTH-1:0]   r_divl,    w_divl_next;
  logic [WIDTH-1:0]       r_shadow,  w_shadow_next;
  logic [WIDTH-1:0]       r_din,     w_din_next;
  logic                   r_start,   w_start_next;
  logic                   r_busy,    w_busy_next;
  logic                   r_overrun, w_overrun_next;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                   w_pop;
  logic                   w_last_pop;
  logic [DIV_WIDTH-1:0]   w_div_clamped;
  logic [COUNT_WIDTH-1:0] w_start_len_m1;
  logic [COUNT_WIDTH-1:0] w_wait_len_m1;

  // Pop whenever we are filling and a word is available. The wcnt bound is
  // redundant with the FILL exit but keeps the strobe safe on its own.
  assign w_pop      = (r_state == S_FILL) && !cfg_fifo_empty && (r_wcnt < NWORDS_L);
  assign w_last_pop = w_pop && (r_wcnt == LAST_WORD);

  assign w_div_clamped = (div > MAX_DIV_L) ? MAX_DIV_L : div;

  // Window lengths in clk_in cycles, minus one because the counter runs to 0.
  assign w_start_len_m1 = (START_BASE << r_divl) - ONE_C;
  assign w_wait_len_m1  = (WAIT_BASE  << r_divl) - ONE_C;

  // ---------------------------------------------------------------------------
  // Shadow image write path: each word slot has its own slice writer, so the
  // popped word lands in slot wcnt. The last slot only takes LAST_BITS bits.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slot
      localparam int LO = gi * WORD_WIDTH;
      localparam int NB = (gi == NWORDS - 1) ? LAST_BITS : WORD_WIDTH;

      assign w_shadow_next[LO +: NB] =
          (w_pop && (r_wcnt == NUM_WIDTH'(gi))) ? cfg_fifo_q[NB-1:0]
                                                : r_shadow[LO +: NB];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_wcnt_next    = r_wcnt;
    w_tcnt_next    = r_tcnt;
    w_divl_next    = r_divl;
    w_din_next     = r_din;
    w_start_next   = r_start;
    w_busy_next    = r_busy;
    // Any load outside IDLE is dropped, including one that lands on the last
    // WAIT cycle, and is remembered until reset.
    w_overrun_next = r_overrun | (load && (r_state != S_IDLE));

    case (r_state)
      S_IDLE: begin
        // Track div while idle so the value present with load is the one kept.
        w_divl_next = w_div_clamped;
        w_wcnt_next = '0;
        if (load) begin
          w_state_next = S_FILL;
          w_busy_next  = 1'b1;
        end
      end

      S_FILL: begin
        if (w_pop) begin
          w_wcnt_next = r_wcnt + ONE_W;
        end
        if (w_last_pop) begin
          // Take the image including the word being popped this cycle so din
          // switches in one step and start rises together with it.
          w_din_next   = w_shadow_next;
          w_tcnt_next  = w_start_len_m1;
          w_start_next = 1'b1;
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (r_tcnt == '0) begin
          w_start_next = 1'b0;
          w_tcnt_next  = w_wait_len_m1;
          w_state_next = S_WAIT;
        end else begin
          w_tcnt_next = r_tcnt - ONE_C;
        end
      end

      S_WAIT: begin
        if (r_tcnt == '0) begin
          w_busy_next  = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          w_tcnt_next = r_tcnt - ONE_C;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
        w_start_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_tcnt    <= '0;
      r_divl    <= '0;
      r_shadow  <= '0;
      r_din     <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_wcnt    <= w_wcnt_next;
      r_tcnt    <= w_tcnt_next;
      r_divl    <= w_divl_next;
      r_shadow  <= w_shadow_next;
      r_din     <= w_din_next;
      r_start   <= w_start_next;
      r_busy    <= w_busy_next;
      r_overrun <= w_overrun_next;
    end
  end

  assign cfg_fifo_rdreq = w_pop;
  assign din            = r_din;
  assign start          = r_start;
  assign busy           = r_busy;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_sr_config_loader.sv
// -----------------------------------------------------------------------------
// tb_sr_config_loader
//
// Self-checking bench for sr_config_loader. A queue models the FWFT config
// FIFO, and the expected image, pop pattern, start length, window length and
// overrun flag are all derived from that queue and the loader's rules. MAX_DIV
// is reduced so that clamping of large div values fits in a short run.
// -----------------------------------------------------------------------------
module tb_sr_config_loader;

  localparam int WIDTH      = 170;
  localparam int WORD_WIDTH = 32;
  localparam int NWORDS     = 6;
  localparam int DIV_WIDTH  = 6;
  localparam int MAX_DIV    = 3;
  localparam int GUARD      = 4;

  logic                  clk_in = 1'b0;
  logic                  rst    = 1'b1;
  logic                  load   = 1'b0;
  logic [DIV_WIDTH-1:0]  div    = '0;
  logic [WORD_WIDTH-1:0] cfg_fifo_q = '0;
  logic                  cfg_fifo_empty = 1'b1;
  logic                  cfg_fifo_rdreq;
  logic [WIDTH-1:0]      din;
  logic                  start;
  logic                  busy;
  logic                  overrun;

  sr_config_loader #(
    .WIDTH      (WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .NWORDS     (NWORDS),
    .NUM_WIDTH  (4),
    .DIV_WIDTH  (DIV_WIDTH),
    .MAX_DIV    (MAX_DIV),
    .COUNT_WIDTH(32),
    .GUARD      (GUARD)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .load          (load),
    .div           (div),
    .cfg_fifo_q    (cfg_fifo_q),
    .cfg_fifo_empty(cfg_fifo_empty),
    .cfg_fifo_rdreq(cfg_fifo_rdreq),
    .din           (din),
    .start         (start),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk_in = ~clk_in;

  // Pop strobe as seen by the clock edge; the FIFO model acts on it afterwards.
  logic rd_seen = 1'b0;
  always @(posedge clk_in) rd_seen <= cfg_fifo_rdreq;

  logic [WORD_WIDTH-1:0] fifo[$];
  logic [WIDTH-1:0]      img_now = '0;  // image din should currently hold
  bit                    ov_exp  = 1'b0;
  int                    kk      = 0;   // cycles since the current load
  int                    g_late_k = -1;
  int                    g_late_n = 0;
  int                    n_tests = 0;
  int                    n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    cfg_fifo_empty = (fifo.size() == 0);
    cfg_fifo_q     = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic push(input logic [WORD_WIDTH-1:0] w);
    fifo.push_back(w);
    drive_fifo();
  endtask

  // One clock: retire the pop taken at the edge, apply scheduled pushes,
  // scramble div (it must have no effect mid-operation), then settle.
  task automatic cycle();
    @(negedge clk_in);
    if (rd_seen && fifo.size() > 0) void'(fifo.pop_front());
    load = 1'b0;
    div  = DIV_WIDTH'($urandom_range(0, 63));
    kk++;
    if (kk == g_late_k) begin
      for (int i = 0; i < g_late_n; i++) fifo.push_back($urandom);
    end
    drive_fifo();
    #1;
  endtask

  // One complete operation: load, fill (possibly stalled), start, window.
  task automatic send(input int d, input int pre, input int late_k, input int late_n,
                      input int ov_k, input bit ov_last);
    logic [WORD_WIDTH-1:0] wq [NWORDS];
    logic [WIDTH-1:0]      exp_img;
    int dl, s_len, n_len, popped, cnt, extra_rd, bound;
    bit exp_rd;

    dl    = (d > MAX_DIV) ? MAX_DIV : d;
    s_len = 2 << dl;
    n_len = (WIDTH + GUARD) << dl;
    for (int i = 0; i < pre; i++) push($urandom);
    g_late_k = late_k;
    g_late_n = late_n;

    load = 1'b1;
    div  = DIV_WIDTH'(d);
    kk   = 0;
    cycle();
    chk("busy_rise", busy, 1'b1);

    popped = 0;
    bound  = 0;
    while (popped < NWORDS && bound < 400) begin
      exp_rd = (fifo.size() > 0);
      chk("rdreq_fill", cfg_fifo_rdreq, exp_rd);
      chk("din_hold", din, img_now);
      chk("start_fill", start, 1'b0);
      if (exp_rd) begin
        wq[popped] = fifo[0];
        popped++;
      end
      if (kk == ov_k) begin
        load   = 1'b1;
        ov_exp = 1'b1;
      end
      cycle();
      bound++;
    end
    if (bound >= 400) chk("fill_timeout", popped, NWORDS);

    exp_img = '0;
    for (int i = 0; i < NWORDS; i++)
      for (int b = 0; b < WORD_WIDTH; b++)
        if (i * WORD_WIDTH + b < WIDTH) exp_img[i * WORD_WIDTH + b] = wq[i][b];

    chk("start_rise", start, 1'b1);
    chk("din_image", din, exp_img);
    img_now = exp_img;

    cnt = 0;
    extra_rd = 0;
    while (start === 1'b1 && cnt < s_len + 10) begin
      extra_rd += int'(cfg_fifo_rdreq);
      if (kk == ov_k) begin
        load   = 1'b1;
        ov_exp = 1'b1;
      end
      cnt++;
      cycle();
    end
    chk("start_len", cnt, s_len);

    cnt = 0;
    while (busy === 1'b1 && cnt < n_len + 10) begin
      extra_rd += int'(cfg_fifo_rdreq);
      if (start !== 1'b0) extra_rd += 100;
      if (kk == ov_k || (ov_last && cnt == n_len - 1)) begin
        load   = 1'b1;
        ov_exp = 1'b1;
      end
      cnt++;
      cycle();
    end
    chk("wait_len", cnt, n_len);
    chk("no_stray_rdreq", extra_rd, 0);
    chk("overrun", overrun, ov_exp);
    chk("din_after", din, img_now);
    $display("[TB] op div=%0d divl=%0d start=%0d wait=%0d overrun=%0b image=%0h",
             d, dl, s_len, n_len, overrun, din);
    if (ov_last) begin
      cycle();
      chk("late_load_ignored", busy, 1'b0);
    end
    g_late_k = -1;
    g_late_n = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dsel [7];
    int pre, ovk;
    dsel = '{0, 1, 2, 3, 5, 40, 63};

    // Reset values
    #12;
    chk("rst_din", din, '0);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdreq", cfg_fifo_rdreq, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    @(negedge clk_in);
    rst = 1'b0;
    cycle();

    // Basic send with a known image
    for (int i = 1; i <= 6; i++) push(32'(i));
    send(0, 0, -1, 0, -1, 1'b0);
    chk("basic_din", din, {10'h006, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
    chk("basic_latency", kk, 183);

    // Stall: two words ready, the rest arrive 20 cycles later
    send(0, 2, 21, 4, -1, 1'b0);

    // Stretch and clamp
    send(2, 6, -1, 0, -1, 1'b0);
    send(40, 6, -1, 0, -1, 1'b0);

    // Overrun while busy, then sticky across later operations
    send(1, 6, -1, 0, 10, 1'b0);
    cycle();
    chk("overrun_sticky", overrun, 1'b1);

    // Load on the final WAIT cycle is dropped
    send(0, 6, -1, 0, -1, 1'b1);

    // Back-to-back with the next image already queued
    send(0, 12, -1, 0, -1, 1'b0);
    send(0, 0, -1, 0, -1, 1'b0);

    // Asynchronous reset in the middle of START
    push(32'hA5A5_0001);
    for (int i = 0; i < 5; i++) push($urandom);
    load = 1'b1;
    div  = '0;
    kk   = 0;
    for (int i = 0; i < 7; i++) cycle();
    chk("mid_start_high", start, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_start", start, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_din", din, '0);
    chk("arst_rdreq", cfg_fifo_rdreq, 1'b0);
    chk("arst_overrun", overrun, 1'b0);
    cycle();
    rst = 1'b0;
    img_now = '0;
    ov_exp  = 1'b0;
    push(32'hDEAD_BEEF);
    cycle();
    cycle();
    chk("post_rst_idle_busy", busy, 1'b0);
    chk("post_rst_idle_rdreq", cfg_fifo_rdreq, 1'b0);
    fifo.delete();
    drive_fifo();

    // Randomized operations
    for (int t = 0; t < 12; t++) begin
      pre = $urandom_range(0, 6);
      ovk = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 7) : -1;
      send(dsel[$urandom_range(0, 6)], pre, $urandom_range(1, 25), 6 - pre, ovk,
           ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
